sw_debouncer: RTL and testbench
===============================

Name: sw_debouncer

Overview:
- Input-conditioning stage directly upstream of the core wrapper's `io_sw` port.
- Synchronises raw board switches/buttons into the core clock domain and debounces each bit independently.
- Presents the clean, stable vector to the core's switch input.
- Also produces per-bit rise/fall strobes and sticky event flags, so software polling via the LSU can detect presses it would otherwise miss.

Parameters:
- WIDTH, 8, number of independent switch bits.
- STABLE_CYCLES, 250000, consecutive cycles a synchronised bit must differ from its debounced value before the debounced value updates. Legal range is ≥ 2.
- CNT_W, $clog2(STABLE_CYCLES), derived localparam: per-bit counter width. Not overridable.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- sw_raw_i  input  WIDTH  raw, asynchronous, bouncing switch levels from the pins.
- sw_o  output  WIDTH  debounced level; drives the core's `io_sw`.
- rise_o  output  WIDTH  one-cycle pulse per bit when sw_o bit goes 0→1.
- fall_o  output  WIDTH  one-cycle pulse per bit when sw_o bit goes 1→0.
- event_o  output  WIDTH  sticky flag per bit, set on any sw_o transition.
- event_clr_i  input  WIDTH  per-bit clear for event_o, level-sampled each cycle.
- any_event_o  output  1  OR-reduction of event_o; registered with event_o.

Behaviour:
- Reset (reset=0, asynchronous):
  - All sync flops, counters, sw_o, rise_o, fall_o, event_o and any_event_o go to 0 immediately.
  - Reset deassertion is taken as synchronous to clk (board reset conditioned externally).
- Synchroniser: two-flop chain per bit, sw_raw_i → s1 → s2. Only s2 is used downstream.
- Per-bit counter cnt[i], evaluated each rising edge:
  - If s2[i] == sw_o[i]: cnt[i] ← 0.
  - Else if cnt[i] == STABLE_CYCLES-1: sw_o[i] ← s2[i]; cnt[i] ← 0.
  - Else: cnt[i] ← cnt[i]+1.
- Counter behaviour:
  - Never wraps; maximum value held is STABLE_CYCLES-1.
  - Any bounce back to the old level before terminal count restarts the count from 0.
- Latency:
  - A raw level captured at edge k and held steady appears on sw_o after edge k+STABLE_CYCLES+1.
  - That is STABLE_CYCLES+2 edges counting the capture edge.
  - Example: STABLE_CYCLES=4 gives sw_o updating on the 6th edge after the raw change.
- Strobes:
  - rise_o[i] = 1 for exactly the one cycle following the edge at which sw_o[i] went 0→1; fall_o[i] likewise for 1→0.
  - Strobes are registered with sw_o; never both high for the same bit.
- Event flags, per bit, each edge:
  - event_o[i] ← (event_o[i] & ~event_clr_i[i]) | rise | fall, where rise/fall are the transitions occurring at that edge.
  - A transition and a clear in the same cycle: set wins (event stays 1).
  - Clear with no transition: event_o[i] = 0 on the next cycle.
- any_event_o is registered in the same cycle as event_o, not derived combinationally from it.
- Switch held high through reset:
  - Not a special case; sw_o starts at 0 and rises STABLE_CYCLES+2 edges after reset release.
  - This produces a rise_o pulse and sets event_o. Firmware clears it at boot.
- Bits are fully independent: simultaneous transitions on several bits produce simultaneous strobes, with no priority between bits.
- Reset asserted mid-count: counters and outputs clear immediately; the count restarts after release.
- No combinational path from any input to any output.

Test Plan:
- Reset / startup:
  - Stimulus: STABLE_CYCLES=4, hold reset=0 with sw_raw_i=8'hFF, then release.
  - Required: all outputs 0 during reset.
  - sw_o=8'hFF on the 6th edge after release; rise_o=8'hFF for 1 cycle; event_o=8'hFF; any_event_o=1.
- Clean press:
  - Stimulus: sw_raw_i bit0 0→1, held.
  - Required: sw_o[0]=1 exactly 6 edges later; rise_o[0] single-cycle pulse; fall_o=0.
- Bounce rejection:
  - Stimulus: bit3 toggles 1,0,1,0 on alternate cycles, then holds 1.
  - Required: no sw_o[3] change during the bounce; sw_o[3]=1 only 6 edges after the final stable 1; exactly one rise_o[3] pulse.
- Glitch shorter than window:
  - Stimulus: bit5 high for 3 cycles, then back to 0.
  - Required: sw_o[5] stays 0; no strobes; event_o[5] stays 0.
- Clear versus set:
  - Stimulus: assert event_clr_i[0]=1 on the same cycle bit0 falls (fall_o[0] asserted next cycle).
  - Required: event_o[0] remains 1.
  - A subsequent clear with no transition gives event_o[0]=0 and any_event_o=0 next cycle.
- Async reset mid-count:
  - Stimulus: bit7 counting (cnt=2); pulse reset low between clock edges.
  - Required: sw_o, event_o and strobes go to 0 immediately, without waiting for an edge.
  - After release with bit7 still high, sw_o[7]=1 on the 6th edge.

Source files
------------

// File: rtl/sw_debouncer.sv
// Switch/button input conditioning: two-flop synchroniser plus per-bit debounce
// counter, with registered rise/fall strobes and sticky, software-clearable event flags.
module sw_debouncer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] event_o,
  input  logic [WIDTH-1:0] event_clr_i,
  output logic             any_event_o
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]            s1_q, s2_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            sw_q, sw_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic [WIDTH-1:0]            event_q, event_d;
  logic                        any_q, any_d;

  // Per-bit debounce: a bit must disagree with sw_q for STABLE_CYCLES edges in a row
  always_comb begin
    sw_d  = sw_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s2_q[i] == sw_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        sw_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    rise_d  = sw_d & ~sw_q;
    fall_d  = ~sw_d & sw_q;
    // A transition in the same cycle as a clear keeps the flag set
    event_d = (event_q & ~event_clr_i) | rise_d | fall_d;
    any_d   = |event_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= '0;
      any_q   <= 1'b0;
    end else begin
      s1_q    <= sw_raw_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
      any_q   <= any_d;
    end
  end

  assign sw_o        = sw_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign event_o     = event_q;
  assign any_event_o = any_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer (STABLE_CYCLES=4): expectations are queued with
// the edge they fall due on and checked by the scoreboard after each clock edge.
module tb_sw_debouncer;

  localparam int unsigned W  = 8;
  localparam int unsigned SC = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_raw_i, event_clr_i;
  logic [W-1:0] sw_o, rise_o, fall_o, event_o;
  logic         any_event_o;

  sw_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw_i   (sw_raw_i),
    .sw_o       (sw_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .event_o    (event_o),
    .event_clr_i(event_clr_i),
    .any_event_o(any_event_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       tag;
    logic [32:0] val;  // {sw, rise, fall, event, any}
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [32:0] obs();
    return {sw_o, rise_o, fall_o, event_o, any_event_o};
  endfunction

  task automatic exp_at(input int d, input string tag, input logic [7:0] sw,
                        input logic [7:0] ri, input logic [7:0] fa,
                        input logic [7:0] ev, input logic an);
    exp_t e;
    e.due = cyc + d;
    e.tag = tag;
    e.val = {sw, ri, fa, ev, an};
    sb.push_back(e);
  endtask

  task automatic compare(input string tag, input logic [32:0] o, input logic [32:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s @cyc%0d: observed sw/rise/fall/evt/any=%h/%h/%h/%h/%b expected %h/%h/%h/%h/%b",
             tag, cyc, o[32:25], o[24:17], o[16:9], o[8:1], o[0],
             e[32:25], e[24:17], e[16:9], e[8:1], e[0]);
    end
  endtask

  // Advance one rising edge, sample 1ns later, retire every expectation due now
  task automatic tick();
    int i;
    @(posedge clk);
    #1;
    cyc++;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        compare(sb[i].tag, obs(), sb[i].val);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset = 1'b0; sw_raw_i = 8'hFF; event_clr_i = 8'h00;

    // Reset held with all switches high
    for (int d = 1; d <= 3; d++) exp_at(d, "in_reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    ticks(3);
    reset = 1'b1;
    for (int d = 1; d <= 5; d++) exp_at(d, "startup_wait", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    exp_at(6, "startup_rise", 8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1);
    exp_at(7, "startup_hold", 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b1);
    ticks(7);
    event_clr_i = 8'hFF;
    exp_at(1, "boot_clear", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    event_clr_i = 8'h00;

    // Release everything
    sw_raw_i = 8'h00;
    exp_at(5, "release_wait", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
    exp_at(6, "release_fall", 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1);
    exp_at(7, "release_hold", 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1);
    ticks(7);
    event_clr_i = 8'hFF;
    exp_at(1, "release_clear", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    event_clr_i = 8'h00;

    // Clean press on bit0
    sw_raw_i = 8'h01;
    for (int d = 1; d <= 5; d++) exp_at(d, "press_wait", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    exp_at(6, "press_rise", 8'h01, 8'h01, 8'h00, 8'h01, 1'b1);
    exp_at(7, "press_hold", 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
    ticks(7);
    event_clr_i = 8'h01;
    exp_at(1, "press_clear", 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    event_clr_i = 8'h00;

    // Bounce on bit3: 1,0,1,0 then steady 1
    for (int b = 0; b < 4; b++) begin
      sw_raw_i = (b % 2 == 0) ? 8'h09 : 8'h01;
      exp_at(1, "bounce_quiet", 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
      tick();
    end
    sw_raw_i = 8'h09;
    for (int d = 1; d <= 5; d++) exp_at(d, "bounce_wait", 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
    exp_at(6, "bounce_rise", 8'h09, 8'h08, 8'h00, 8'h08, 1'b1);
    exp_at(7, "bounce_hold", 8'h09, 8'h00, 8'h00, 8'h08, 1'b1);
    ticks(7);
    event_clr_i = 8'h08;
    exp_at(1, "bounce_clear", 8'h09, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    event_clr_i = 8'h00;

    // Three-cycle glitch on bit5 must be rejected
    for (int d = 1; d <= 9; d++) exp_at(d, "glitch", 8'h09, 8'h00, 8'h00, 8'h00, 1'b0);
    sw_raw_i = 8'h29;
    ticks(3);
    sw_raw_i = 8'h09;
    ticks(6);

    // Bit0 falls with clear asserted on the transition edge: set wins
    sw_raw_i = 8'h08;
    for (int d = 1; d <= 5; d++) exp_at(d, "fall_wait", 8'h09, 8'h00, 8'h00, 8'h00, 1'b0);
    ticks(5);
    event_clr_i = 8'h01;
    exp_at(1, "set_wins", 8'h08, 8'h00, 8'h01, 8'h01, 1'b1);
    tick();
    event_clr_i = 8'h00;
    exp_at(1, "evt_sticky", 8'h08, 8'h00, 8'h00, 8'h01, 1'b1);
    tick();
    event_clr_i = 8'h01;
    exp_at(1, "clr_alone", 8'h08, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    event_clr_i = 8'h00;

    // Async reset while bit7 is mid-count
    sw_raw_i = 8'h88;
    for (int d = 1; d <= 4; d++) exp_at(d, "pre_reset", 8'h08, 8'h00, 8'h00, 8'h00, 1'b0);
    ticks(4);
    #2 reset = 1'b0;
    #1 compare("async_reset", obs(), 33'h0);
    reset = 1'b1;
    for (int d = 1; d <= 5; d++) exp_at(d, "post_reset_wait", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    exp_at(6, "post_reset_rise", 8'h88, 8'h88, 8'h00, 8'h88, 1'b1);
    exp_at(7, "post_reset_hold", 8'h88, 8'h00, 8'h00, 8'h88, 1'b1);
    ticks(7);

    // Every queued expectation must have been retired
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
